// File: rtl/jtbubl_sndcomm_pkg.sv
// Shared constants for the main-to-sound command channel.
// Holds the sound-side register offsets, the default reset stretch and the status byte layout.
package jtbubl_sndcomm_pkg;

    localparam logic [1:0] SNDCOMM_CMD    = 2'd0;
    localparam logic [1:0] SNDCOMM_NMIEN  = 2'd1;
    localparam logic [1:0] SNDCOMM_NMIDIS = 2'd2;
    localparam logic [1:0] SNDCOMM_STAT   = 2'd3;

    localparam int unsigned SNDCOMM_RSTLEN = 16;

    function automatic logic [7:0] sndcomm_status(input logic reply_pending,
                                                  input logic cmd_pending);
        return {6'b0, reply_pending, cmd_pending};
    endfunction

endpackage

// File: rtl/jtbubl_sndcomm_acc.sv
// Sound CPU bus access edge detector.
// Strobes are sampled only on cen, so each access produces exactly one start (and one read end) pulse.
module jtbubl_sndcomm_acc (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cen_i,
    input  logic cs_i,
    input  logic rdn_i,
    input  logic wrn_i,
    output logic rd_start_o,
    output logic rd_end_o,
    output logic wr_start_o
);

    logic rd_act, wr_act;
    logic rd_act_q, wr_act_q;

    assign rd_act = cs_i & ~rdn_i;
    assign wr_act = cs_i & ~wrn_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
        end else if (cen_i) begin
            rd_act_q <= rd_act;
            wr_act_q <= wr_act;
        end
    end

    assign rd_start_o = cen_i &  rd_act & ~rd_act_q;
    assign rd_end_o   = cen_i & ~rd_act &  rd_act_q;
    assign wr_start_o = cen_i &  wr_act & ~wr_act_q;

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Sound-board end of the main/sound command channel: command latch with gated NMI,
// reply latch back to the main CPU, and a cen-timed stretch of the main-driven sound reset.
module jtbubl_sndcomm
    import jtbubl_sndcomm_pkg::*;
#(
    parameter int unsigned RSTLEN = SNDCOMM_RSTLEN
) (
    input  logic       clk24,
    input  logic       rst,
    input  logic       cen,
    input  logic       main_latch_wr,
    input  logic [7:0] main_latch,
    input  logic       main_reply_rd,
    output logic [7:0] main_reply,
    output logic       reply_pending,
    input  logic       main_snd_rst,
    output logic       snd_rst,
    input  logic       snd_cs,
    input  logic [1:0] snd_addr,
    input  logic       snd_rdn,
    input  logic       snd_wrn,
    input  logic [7:0] snd_dout,
    output logic [7:0] snd_din,
    output logic       nmi_n
);

    localparam logic [7:0] RSTLEN_V = 8'(RSTLEN);

    logic       rd_start, rd_end, wr_start;

    logic [7:0] cmd_q, cmd_d;
    logic       cmd_pending_q, cmd_pending_d;
    logic       nmi_en_q, nmi_en_d;
    logic [7:0] main_reply_q, main_reply_d;
    logic       reply_pending_q, reply_pending_d;
    logic       nmi_n_q, nmi_n_d;
    logic [7:0] rst_cnt_q, rst_cnt_d;
    logic       rd_cmd_q, rd_cmd_d;

    jtbubl_sndcomm_acc u_acc (
        .clk_i      (clk24),
        .rst_i      (rst),
        .cen_i      (cen),
        .cs_i       (snd_cs),
        .rdn_i      (snd_rdn),
        .wrn_i      (snd_wrn),
        .rd_start_o (rd_start),
        .rd_end_o   (rd_end),
        .wr_start_o (wr_start)
    );

    assign snd_rst = main_snd_rst | (rst_cnt_q != 8'd0);

    always_comb begin
        cmd_d           = cmd_q;
        cmd_pending_d   = cmd_pending_q;
        nmi_en_d        = nmi_en_q;
        main_reply_d    = main_reply_q;
        reply_pending_d = reply_pending_q;
        rd_cmd_d        = rd_cmd_q;
        rst_cnt_d       = rst_cnt_q;
        nmi_n_d         = ~(cmd_pending_q & nmi_en_q);

        // The read address is captured at access start, so the clear keys off the access as issued.
        if (rd_start) rd_cmd_d = (snd_addr == SNDCOMM_CMD);
        if (rd_end && rd_cmd_q) cmd_pending_d = 1'b0;
        if (main_latch_wr) begin
            cmd_d         = main_latch;
            cmd_pending_d = 1'b1;
        end

        if (main_reply_rd) reply_pending_d = 1'b0;
        if (wr_start) begin
            case (snd_addr)
                SNDCOMM_CMD: begin
                    main_reply_d    = snd_dout;
                    reply_pending_d = 1'b1;
                end
                SNDCOMM_NMIEN:  nmi_en_d = 1'b1;
                SNDCOMM_NMIDIS: nmi_en_d = 1'b0;
                default: ;
            endcase
        end

        if (snd_rst) begin
            nmi_en_d        = 1'b0;
            reply_pending_d = 1'b0;
            main_reply_d    = main_reply_q;
        end

        // Holding the load while the request is high makes the release itself the reload point.
        if (main_snd_rst) rst_cnt_d = RSTLEN_V;
        else if (cen && rst_cnt_q != 8'd0) rst_cnt_d = rst_cnt_q - 8'd1;
    end

    always_ff @(posedge clk24 or posedge rst) begin
        if (rst) begin
            cmd_q           <= 8'd0;
            cmd_pending_q   <= 1'b0;
            nmi_en_q        <= 1'b0;
            main_reply_q    <= 8'd0;
            reply_pending_q <= 1'b0;
            nmi_n_q         <= 1'b1;
            rst_cnt_q       <= RSTLEN_V;
            rd_cmd_q        <= 1'b0;
        end else begin
            cmd_q           <= cmd_d;
            cmd_pending_q   <= cmd_pending_d;
            nmi_en_q        <= nmi_en_d;
            main_reply_q    <= main_reply_d;
            reply_pending_q <= reply_pending_d;
            nmi_n_q         <= nmi_n_d;
            rst_cnt_q       <= rst_cnt_d;
            rd_cmd_q        <= rd_cmd_d;
        end
    end

    always_comb begin
        case (snd_addr)
            SNDCOMM_CMD:  snd_din = cmd_q;
            SNDCOMM_STAT: snd_din = sndcomm_status(reply_pending_q, cmd_pending_q);
            default:      snd_din = 8'hFF;
        endcase
    end

    assign main_reply    = main_reply_q;
    assign reply_pending = reply_pending_q;
    assign nmi_n         = nmi_n_q;

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Bench for jtbubl_sndcomm: directed scenarios plus random bus transactions
// checked against a transaction-level model of the channel state.
module tb_jtbubl_sndcomm;

    localparam int RSTLEN = 16;

    logic       clk24 = 1'b0;
    logic       rst;
    logic       cen;
    logic       main_latch_wr;
    logic [7:0] main_latch;
    logic       main_reply_rd;
    logic [7:0] main_reply;
    logic       reply_pending;
    logic       main_snd_rst;
    logic       snd_rst;
    logic       snd_cs;
    logic [1:0] snd_addr;
    logic       snd_rdn;
    logic       snd_wrn;
    logic [7:0] snd_dout;
    logic [7:0] snd_din;
    logic       nmi_n;

    int n_vec = 0;
    int n_err = 0;
    int ph    = 0;
    logic [7:0] exp_q[$];

    // Reference state of the channel, updated once per completed transaction
    logic [7:0] m_cmd, m_reply;
    logic       m_cp, m_en, m_rp;

    jtbubl_sndcomm #(.RSTLEN(RSTLEN)) dut (
        .clk24         (clk24),
        .rst           (rst),
        .cen           (cen),
        .main_latch_wr (main_latch_wr),
        .main_latch    (main_latch),
        .main_reply_rd (main_reply_rd),
        .main_reply    (main_reply),
        .reply_pending (reply_pending),
        .main_snd_rst  (main_snd_rst),
        .snd_rst       (snd_rst),
        .snd_cs        (snd_cs),
        .snd_addr      (snd_addr),
        .snd_rdn       (snd_rdn),
        .snd_wrn       (snd_wrn),
        .snd_dout      (snd_dout),
        .snd_din       (snd_din),
        .nmi_n         (nmi_n)
    );

    // clock and cen (one pulse every four clk24 cycles)
    always #5 clk24 = ~clk24;

    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk24);
            #1;
            ph  = (ph + 1) % 4;
            cen = (ph == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_din(input logic [1:0] a);
        if (a == 2'd0) return m_cmd;
        if (a == 2'd3) return {6'b0, m_rp, m_cp};
        return 8'hFF;
    endfunction

    // Returns mid-cycle with the next rising edge being a cen edge
    task automatic to_cen_slot();
        int guard = 0;
        @(posedge clk24);
        #2;
        while (cen !== 1'b1 && guard < 16) begin
            @(posedge clk24);
            #2;
            guard++;
        end
        if (cen !== 1'b1) check_val("cen_timeout", 8'(cen), 8'h01);
    endtask

    task automatic main_cmd(input logic [7:0] d);
        @(posedge clk24);
        #2;
        main_latch_wr = 1'b1;
        main_latch    = d;
        @(posedge clk24);
        #2;
        main_latch_wr = 1'b0;
        m_cmd = d;
        m_cp  = 1'b1;
    endtask

    task automatic main_rd();
        @(posedge clk24);
        #2;
        main_reply_rd = 1'b1;
        @(posedge clk24);
        #2;
        main_reply_rd = 1'b0;
        m_rp = 1'b0;
    endtask

    // race=1: a main strobe lands on the same clk24 as the access edge
    // (reply read at a write start, command write at a read end)
    task automatic snd_access(input logic wr, input logic [1:0] a, input logic [7:0] d,
                              input logic race, input logic [7:0] race_cmd);
        to_cen_slot();
        snd_cs   = 1'b1;
        snd_addr = a;
        snd_dout = d;
        if (wr) snd_wrn = 1'b0;
        else    snd_rdn = 1'b0;
        if (race && wr) main_reply_rd = 1'b1;
        if (!wr) exp_q.push_back(exp_din(a));
        @(posedge clk24);
        #2;
        main_reply_rd = 1'b0;
        repeat ($urandom_range(0, 2)) to_cen_slot();
        if (!wr) check_val("rd_data", snd_din, exp_q.pop_front());
        to_cen_slot();
        snd_cs  = 1'b0;
        snd_rdn = 1'b1;
        snd_wrn = 1'b1;
        if (race && !wr) begin
            main_latch_wr = 1'b1;
            main_latch    = race_cmd;
        end
        @(posedge clk24);
        #2;
        main_latch_wr = 1'b0;
        if (wr) begin
            if (a == 2'd0) begin
                m_reply = d;
                m_rp    = 1'b1;
            end else if (race) begin
                m_rp = 1'b0;
            end
            if (a == 2'd1) m_en = 1'b1;
            if (a == 2'd2) m_en = 1'b0;
        end else begin
            if (a == 2'd0) m_cp = 1'b0;
            if (race) begin
                m_cmd = race_cmd;
                m_cp  = 1'b1;
            end
        end
    endtask

    // Counts cen pulses from now until snd_rst drops
    task automatic count_stretch(input string tag);
        int pulses = 0;
        int guard  = 0;
        while (snd_rst === 1'b1 && guard < 1000) begin
            @(posedge clk24);
            if (cen === 1'b1) pulses++;
            #1;
            guard++;
        end
        check_val(tag, 8'(pulses), 8'(RSTLEN));
    endtask

    task automatic pulse_snd_rst();
        @(posedge clk24);
        #2;
        main_snd_rst = 1'b1;
        #1;
        check_val("snd_rst_req", 8'(snd_rst), 8'h01);
        repeat ($urandom_range(2, 8)) @(posedge clk24);
        #2;
        main_snd_rst = 1'b0;
        count_stretch("snd_rst_stretch");
        m_en = 1'b0;
        m_rp = 1'b0;
    endtask

    // scoreboard: compare every observable against the model
    task automatic check_all();
        repeat (2) @(posedge clk24);
        @(negedge clk24);
        check_val("nmi_n", 8'(nmi_n), 8'(!(m_cp && m_en)));
        check_val("main_reply", main_reply, m_reply);
        check_val("reply_pending", 8'(reply_pending), 8'(m_rp));
        check_val("snd_rst_idle", 8'(snd_rst), 8'h00);
        snd_addr = 2'd0;
        #1;
        check_val("cmd", snd_din, m_cmd);
        snd_addr = 2'd3;
        #1;
        check_val("status", snd_din, {6'b0, m_rp, m_cp});
        snd_addr = 2'($urandom_range(1, 2));
        #1;
        check_val("unmapped", snd_din, 8'hFF);
    endtask

    initial begin
        logic [7:0] rd8;
        logic [1:0] ra;
        logic       rr;

        rst = 1'b1;
        main_latch_wr = 1'b0;
        main_latch    = 8'h00;
        main_reply_rd = 1'b0;
        main_snd_rst  = 1'b0;
        snd_cs   = 1'b0;
        snd_addr = 2'd0;
        snd_rdn  = 1'b1;
        snd_wrn  = 1'b1;
        snd_dout = 8'h00;
        m_cmd = 8'h00; m_reply = 8'h00;
        m_cp  = 1'b0;  m_en = 1'b0; m_rp = 1'b0;

        // reset state
        repeat (3) @(posedge clk24);
        @(negedge clk24);
        check_val("rst_snd_rst", 8'(snd_rst), 8'h01);
        check_val("rst_nmi_n", 8'(nmi_n), 8'h01);
        check_val("rst_main_reply", main_reply, 8'h00);
        check_val("rst_reply_pending", 8'(reply_pending), 8'h00);
        snd_addr = 2'd3;
        #1;
        check_val("rst_status", snd_din, 8'h00);
        @(posedge clk24);
        #2;
        rst = 1'b0;
        count_stretch("rst_stretch");

        // command with NMI enabled
        snd_access(1'b1, 2'd1, 8'h00, 1'b0, 8'h00);
        main_cmd(8'h5A);
        check_val("nmi_before", 8'(nmi_n), 8'h01);
        @(posedge clk24);
        #1;
        check_val("nmi_asserted", 8'(nmi_n), 8'h00);
        snd_addr = 2'd3;
        #1;
        check_val("status_cmd", snd_din, 8'h01);
        snd_access(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        check_val("nmi_at_end", 8'(nmi_n), 8'h00);
        @(posedge clk24);
        #1;
        check_val("nmi_released", 8'(nmi_n), 8'h01);
        check_all();

        // command pending before enable
        snd_access(1'b1, 2'd2, 8'h00, 1'b0, 8'h00);
        main_cmd(8'h33);
        check_all();
        snd_access(1'b1, 2'd1, 8'h00, 1'b0, 8'h00);
        check_all();
        snd_access(1'b1, 2'd2, 8'h00, 1'b0, 8'h00);
        check_all();

        // reply path, including set-wins against a main read
        snd_access(1'b1, 2'd0, 8'hC4, 1'b0, 8'h00);
        check_all();
        main_rd();
        check_all();
        snd_access(1'b1, 2'd0, 8'h1E, 1'b1, 8'h00);
        check_all();

        // command write lands on the read end edge
        snd_access(1'b0, 2'd0, 8'h00, 1'b1, 8'h77);
        check_all();

        // reset stretch keeps cmd and reply byte
        snd_access(1'b1, 2'd1, 8'h00, 1'b0, 8'h00);
        check_all();
        pulse_snd_rst();
        check_all();

        // random transactions
        for (int i = 0; i < 80; i++) begin
            rd8 = 8'($urandom_range(0, 255));
            ra  = 2'($urandom_range(0, 3));
            rr  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 11))
                0, 1:    main_cmd(rd8);
                2, 3:    main_rd();
                4, 5, 6: snd_access(1'b0, ra, 8'h00, rr, rd8);
                7, 8, 9: snd_access(1'b1, ra, rd8, rr, 8'h00);
                10:      snd_access(1'b1, 2'd1, 8'h00, 1'b0, 8'h00);
                default: if (i % 4 == 0) pulse_snd_rst(); else main_cmd(rd8);
            endcase
            check_all();
        end

        // async reset in the middle of a command read
        snd_access(1'b1, 2'd0, 8'hA5, 1'b0, 8'h00);
        snd_access(1'b1, 2'd1, 8'h00, 1'b0, 8'h00);
        main_cmd(8'h3C);
        check_all();
        to_cen_slot();
        snd_cs   = 1'b1;
        snd_addr = 2'd0;
        snd_rdn  = 1'b0;
        @(posedge clk24);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_snd_rst", 8'(snd_rst), 8'h01);
        check_val("arst_nmi_n", 8'(nmi_n), 8'h01);
        check_val("arst_main_reply", main_reply, 8'h00);
        check_val("arst_reply_pending", 8'(reply_pending), 8'h00);
        check_val("arst_cmd", snd_din, 8'h00);
        snd_cs  = 1'b0;
        snd_rdn = 1'b1;
        @(posedge clk24);
        #2;
        rst = 1'b0;
        m_cmd = 8'h00; m_reply = 8'h00;
        m_cp  = 1'b0;  m_en = 1'b0; m_rp = 1'b0;
        count_stretch("arst_stretch");
        main_cmd(8'h6B);
        repeat (12) @(posedge clk24);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
